// File: rtl/inverse_sub_bytes_seq.sv
// inverse_sub_bytes_seq: multi-cycle AES InvSubBytes, LANES bytes per clock through a 3-state FSM.
// Define ISB_FUSED_ARK_EN to add a round_key port and XOR the key into every substituted byte.
module inverse_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out,
    output logic         out_valid,
    input  logic         out_ready
`ifdef ISB_FUSED_ARK_EN
    ,
    input  logic [0:127] round_key
`endif
);
    localparam logic [3:0] LAST = 4'(16 / LANES - 1);
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [0:127] st, nxt;
    logic [6:0] pos;
`ifdef ISB_FUSED_ARK_EN
    logic [0:127] key;
`endif

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    assign out = st;

    // Only the LANES bytes of the current group are substituted; the rest pass through.
    always_comb begin
        nxt = st;
        pos = '0;
        for (int i = 0; i < LANES; i++) begin
            pos = 7'((int'(cnt) * LANES + i) * 8);
`ifdef ISB_FUSED_ARK_EN
            nxt[pos +: 8] = inv_sbox(st[pos +: 8]) ^ key[pos +: 8];
`else
            nxt[pos +: 8] = inv_sbox(st[pos +: 8]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
`ifdef ISB_FUSED_ARK_EN
            key       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        st       <= in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
`ifdef ISB_FUSED_ARK_EN
                        key      <= round_key;
`endif
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    st  <= nxt;
                    cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
